// File: rtl/pconv_tm.sv
// Time-multiplexed pointwise convolution: PE_NUM MAC lanes sweep the output channels
// group by group for each pixel. Define PCONV_TM_RELU_EN to clamp negative outputs to zero.
module pconv_tm #(
    parameter int  N              = 16,
    parameter int  INPUT_CHANNEL  = 3,
    parameter int  INPUT_SIZE     = 6,
    parameter int  OUTPUT_CHANNEL = 32,
    parameter int  PE_NUM         = 8,
    localparam int GROUPS         = OUTPUT_CHANNEL / PE_NUM,
    localparam int GW             = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_vld,
    output logic                                     in_rdy,
    input  logic [INPUT_CHANNEL*N-1:0]               in_din,
    input  logic [OUTPUT_CHANNEL*INPUT_CHANNEL*N-1:0] weight_din,
    input  logic [OUTPUT_CHANNEL*32-1:0]             bias_din,
    input  logic [OUTPUT_CHANNEL*5-1:0]              shift_din,
    output logic                                     out_vld,
    input  logic                                     out_rdy,
    output logic [PE_NUM*N-1:0]                      out_dout,
    output logic [GW-1:0]                            out_grp,
    output logic                                     out_last,
    output logic                                     frame_done,
    output logic [1:0]                               state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

    localparam int PIXELS  = INPUT_SIZE * INPUT_SIZE;
    localparam int KW      = (INPUT_CHANNEL > 1) ? $clog2(INPUT_CHANNEL) : 1;
    localparam int PW      = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int SAT_MAX = (2 ** (N - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (N - 1));
    localparam logic [KW-1:0] K_LAST = KW'(INPUT_CHANNEL - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PIXELS - 1);

    state_t                     state_q, state_d;
    logic [INPUT_CHANNEL*N-1:0] x_q;
    logic [KW-1:0]              k_q;
    logic [GW-1:0]              g_q;
    logic [PW-1:0]              pix_q;
    logic                       last_q;
    logic                       frame_done_q;
    logic signed [31:0]         acc_q   [PE_NUM];
    logic signed [31:0]         acc_d   [PE_NUM];

    logic                       in_hs, out_hs;
    logic [GW-1:0]              g_load;
    logic signed [N-1:0]        x_k;
    logic signed [N-1:0]        w_k     [PE_NUM];
    logic signed [2*N-1:0]      prod    [PE_NUM];
    logic signed [31:0]         shifted [PE_NUM];
    logic signed [31:0]         lane_v  [PE_NUM];
    logic [PE_NUM*N-1:0]        dout_c;

    // Both ports are valid/ready: a beat transfers on a rising edge where valid and ready
    // are both high; the producer holds valid and payload unchanged until that edge.
    assign in_rdy     = (state_q == IDLE);
    assign out_vld    = (state_q == OUT);
    assign in_hs      = in_vld & in_rdy;
    assign out_hs     = out_vld & out_rdy;
    assign out_grp    = g_q;
    assign out_last   = out_vld & last_q & (g_q == G_LAST);
    assign out_dout   = dout_c;
    assign frame_done = frame_done_q;
    assign state_o    = state_q;
    assign x_k        = x_q[int'(k_q)*N +: N];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_vld) state_d = MAC;
            MAC:     if (k_q == K_LAST) state_d = OUT;
            OUT:     if (out_rdy) state_d = (g_q == G_LAST) ? IDLE : MAC;
            default: state_d = IDLE;
        endcase
    end

    // Bias reload targets group 0 on a new pixel, otherwise the group about to be computed.
    always_comb begin
        g_load = (in_hs || g_q == G_LAST) ? '0 : g_q + 1'b1;
        dout_c = '0;
        for (int p = 0; p < PE_NUM; p++) begin
            w_k[p]  = weight_din[((int'(g_q)*PE_NUM + p)*INPUT_CHANNEL + int'(k_q))*N +: N];
            prod[p] = x_k * w_k[p];
            acc_d[p] = acc_q[p];
            if (in_hs || (out_hs && g_q != G_LAST))
                acc_d[p] = $signed(bias_din[(int'(g_load)*PE_NUM + p)*32 +: 32]);
            else if (state_q == MAC)
                acc_d[p] = acc_q[p] + 32'(prod[p]);
            shifted[p] = acc_q[p] >>> shift_din[(int'(g_q)*PE_NUM + p)*5 +: 5];
            if (shifted[p] > SAT_MAX)
                lane_v[p] = SAT_MAX;
            else if (shifted[p] < SAT_MIN)
                lane_v[p] = SAT_MIN;
            else
                lane_v[p] = shifted[p];
`ifdef PCONV_TM_RELU_EN
            if (lane_v[p] < 0) lane_v[p] = '0;
`endif
            if (state_q == OUT) dout_c[p*N +: N] = lane_v[p][N-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            k_q          <= '0;
            g_q          <= '0;
            pix_q        <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int p = 0; p < PE_NUM; p++) acc_q[p] <= '0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= out_hs & out_last;
            for (int p = 0; p < PE_NUM; p++) acc_q[p] <= acc_d[p];
            if (in_hs) begin
                x_q    <= in_din;
                k_q    <= '0;
                g_q    <= '0;
                last_q <= (pix_q == P_LAST);
                pix_q  <= (pix_q == P_LAST) ? '0 : pix_q + 1'b1;
            end else if (state_q == MAC) begin
                k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
            end else if (out_hs) begin
                g_q <= g_load;
            end
        end
    end

endmodule

// File: tb/tb_pconv_tm.sv
// Self-checking bench for pconv_tm: directed corner pixels plus randomized pixels checked
// against an arithmetic reference model. Honours PCONV_TM_RELU_EN when defined.
`timescale 1ns/1ps
module tb_pconv_tm;
  localparam int N      = 16;
  localparam int IC     = 3;
  localparam int ISZ    = 6;
  localparam int OC     = 32;
  localparam int PE     = 8;
  localparam int GROUPS = OC / PE;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int PIXELS = ISZ * ISZ;
  localparam int W      = PE * N;
  localparam int SMAX   = (2 ** (N - 1)) - 1;
  localparam int SMIN   = -(2 ** (N - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_vld = 1'b0;
  logic out_rdy = 1'b1;
  logic in_rdy, out_vld, out_last, frame_done;
  logic [IC*N-1:0] in_din = '0;
  logic [OC*IC*N-1:0] weight_din = '0;
  logic [OC*32-1:0] bias_din = '0;
  logic [OC*5-1:0] shift_din = '0;
  logic [W-1:0] out_dout;
  logic [GW-1:0] out_grp;
  logic [1:0] state_o;

  int total = 0;
  int bad = 0;
  int pix_cnt = 0;
  logic [W-1:0] exp_q[$];

  logic [W-1:0] obs_dout[GROUPS];
  logic [GW-1:0] obs_grp[GROUPS];
  logic obs_last[GROUPS];
  int obs_lat, obs_ok, obs_hold_bad, obs_rdy_bad, fd_count;
  logic obs_fd_after;

  pconv_tm #(.N(N), .INPUT_CHANNEL(IC), .INPUT_SIZE(ISZ), .OUTPUT_CHANNEL(OC), .PE_NUM(PE)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_din(in_din),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dout(out_dout), .out_grp(out_grp),
    .out_last(out_last), .frame_done(frame_done), .state_o(state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Sum in 64 bits, then keep the low 32 bits to get the accumulator's wraparound.
  function automatic logic [W-1:0] model_beat(input logic [IC*N-1:0] x, input int g);
    logic [W-1:0] r;
    r = '0;
    for (int p = 0; p < PE; p++) begin
      int o;
      int sh;
      longint acc;
      logic signed [31:0] a32;
      logic signed [31:0] v;
      logic signed [N-1:0] xc;
      logic signed [N-1:0] wc;
      o = g * PE + p;
      acc = longint'($signed(bias_din[o*32 +: 32]));
      for (int c = 0; c < IC; c++) begin
        xc = x[c*N +: N];
        wc = weight_din[(o*IC + c)*N +: N];
        acc += longint'(xc) * longint'(wc);
      end
      a32 = acc[31:0];
      sh = int'(shift_din[o*5 +: 5]);
      v = a32 >>> sh;
      if (v > SMAX) v = SMAX;
      else if (v < SMIN) v = SMIN;
`ifdef PCONV_TM_RELU_EN
      if (v < 0) v = 0;
`endif
      r[p*N +: N] = v[N-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] lanes(input int v);
    logic [W-1:0] r;
    for (int p = 0; p < PE; p++) r[p*N +: N] = N'(v);
    return r;
  endfunction

  function automatic logic [IC*N-1:0] mk_pixel(input int c0, input int c1, input int c2);
    return {N'(c2), N'(c1), N'(c0)};
  endfunction

  function automatic logic [IC*N-1:0] rand_pixel();
    logic [IC*N-1:0] r;
    for (int c = 0; c < IC; c++) r[c*N +: N] = N'($urandom);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_uniform(input int w, input int b, input int s);
    for (int o = 0; o < OC; o++) begin
      for (int c = 0; c < IC; c++) weight_din[(o*IC + c)*N +: N] = N'(w);
      bias_din[o*32 +: 32] = 32'(b);
      shift_din[o*5 +: 5] = 5'(s);
    end
  endtask

  task automatic set_random();
    for (int o = 0; o < OC; o++) begin
      for (int c = 0; c < IC; c++) weight_din[(o*IC + c)*N +: N] = N'($urandom);
      bias_din[o*32 +: 32] = $urandom_range(2000000, 0) - 32'd1000000;
      shift_din[o*5 +: 5] = 5'($urandom_range(20, 0));
    end
  endtask

  // Sends one pixel, then collects its GROUPS beats; optionally stalls beat stall_grp.
  task automatic drive_pixel(input logic [IC*N-1:0] x, input int stall_grp, input int stall_cycles);
    int cyc;
    int nb;
    int left;
    logic [W+GW-1:0] hold_ref;
    obs_ok = 1; obs_lat = -1; obs_hold_bad = 0; obs_rdy_bad = 0; hold_ref = '0;
    for (int g = 0; g < GROUPS; g++) begin
      obs_dout[g] = '0; obs_grp[g] = '0; obs_last[g] = 1'b0;
    end
    in_din = x; in_vld = 1'b1; out_rdy = 1'b1;
    cyc = 0;
    while (!in_rdy && cyc < 64) begin
      @(negedge clk); cyc++;
    end
    if (!in_rdy) begin
      obs_ok = 0; in_vld = 1'b0;
      return;
    end
    @(negedge clk);
    in_vld = 1'b0; in_din = ~x;
    pix_cnt++;
    cyc = 1; nb = 0; left = stall_cycles;
    while (nb < GROUPS && cyc < 400) begin
      if (out_vld) begin
        if (obs_lat < 0) obs_lat = cyc;
        if (nb == stall_grp && left > 0) begin
          if (left == stall_cycles) hold_ref = {out_dout, out_grp};
          else if ({out_dout, out_grp} !== hold_ref) obs_hold_bad++;
          if (in_rdy !== 1'b0) obs_rdy_bad++;
          out_rdy = 1'b0; left--;
        end else begin
          if (nb == stall_grp && stall_cycles > 0 && {out_dout, out_grp} !== hold_ref) obs_hold_bad++;
          out_rdy = 1'b1;
          obs_dout[nb] = out_dout; obs_grp[nb] = out_grp; obs_last[nb] = out_last;
          nb++;
        end
      end
      if (frame_done) fd_count++;
      @(negedge clk); cyc++;
    end
    if (nb < GROUPS) obs_ok = 0;
    out_rdy = 1'b1;
    obs_fd_after = frame_done;
    if (frame_done) fd_count++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_out_vld got=%b want=0", out_vld); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    total++; if (out_dout !== '0) begin bad++; $display("FAIL reset_out_dout got=%h want=0", out_dout); end
    total++; if (out_grp !== '0) begin bad++; $display("FAIL reset_out_grp got=%0d want=0", out_grp); end
    rst_n = 1'b1; in_vld = 1'b0; pix_cnt = 0;
    @(negedge clk);
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy got=%b want=1", in_rdy); end
  endtask

  task automatic test_basic();
    set_uniform(1, 0, 0);
    drive_pixel(mk_pixel(1, 2, 3), -1, 0);
    total++; if (obs_ok != 1) begin bad++; $display("FAIL basic_timeout got=%0d want=1", obs_ok); end
    total++; if (obs_lat != IC + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", obs_lat, IC + 1); end
    for (int g = 0; g < GROUPS; g++) begin
      total++; if (obs_dout[g] !== lanes(6)) begin bad++; $display("FAIL basic_dout g=%0d got=%h want=%h", g, obs_dout[g], lanes(6)); end
      total++; if (obs_grp[g] !== GW'(g)) begin bad++; $display("FAIL basic_grp got=%0d want=%0d", obs_grp[g], g); end
    end
  endtask

  // Three full-scale products overflow the 32-bit accumulator and wrap; two do not.
  task automatic test_saturation();
    logic [IC*N-1:0] xs[4];
    logic [W-1:0] want;
    int neg;
`ifdef PCONV_TM_RELU_EN
    neg = 0;
`else
    neg = SMIN;
`endif
    set_uniform(32767, 0, 0);
    xs[0] = mk_pixel(32767, 32767, 0);
    xs[1] = mk_pixel(-32767, -32767, 0);
    xs[2] = mk_pixel(32767, 32767, 32767);
    xs[3] = mk_pixel(-32767, -32767, -32767);
    for (int t = 0; t < 4; t++) begin
      drive_pixel(xs[t], -1, 0);
      total++; if (obs_ok != 1) begin bad++; $display("FAIL sat_timeout t=%0d got=%0d want=1", t, obs_ok); end
      for (int g = 0; g < GROUPS; g++) begin
        if (t == 0) want = lanes(SMAX);
        else if (t == 1) want = lanes(neg);
        else want = model_beat(xs[t], g);
        total++; if (obs_dout[g] !== want) begin bad++; $display("FAIL sat_dout t=%0d g=%0d got=%h want=%h", t, g, obs_dout[g], want); end
      end
    end
  endtask

  task automatic test_bias_shift();
    logic [W-1:0] want;
`ifdef PCONV_TM_RELU_EN
    want = lanes(0);
`else
    want = lanes(-24);
`endif
    set_uniform(1, -100, 2);
    drive_pixel(mk_pixel(4, 0, 0), -1, 0);
    total++; if (obs_ok != 1) begin bad++; $display("FAIL bias_timeout got=%0d want=1", obs_ok); end
    for (int g = 0; g < GROUPS; g++) begin
      total++; if (obs_dout[g] !== want) begin bad++; $display("FAIL bias_shift_dout g=%0d got=%h want=%h", g, obs_dout[g], want); end
    end
  endtask

  task automatic test_stall();
    logic [IC*N-1:0] x;
    logic [W-1:0] want;
    set_random();
    x = rand_pixel();
    for (int g = 0; g < GROUPS; g++) exp_q.push_back(model_beat(x, g));
    drive_pixel(x, 1, 5);
    total++; if (obs_ok != 1) begin bad++; $display("FAIL stall_timeout got=%0d want=1", obs_ok); end
    total++; if (obs_hold_bad != 0) begin bad++; $display("FAIL stall_hold changes=%0d want=0", obs_hold_bad); end
    total++; if (obs_rdy_bad != 0) begin bad++; $display("FAIL stall_in_rdy high_cycles=%0d want=0", obs_rdy_bad); end
    for (int g = 0; g < GROUPS; g++) begin
      want = exp_q.pop_front();
      total++; if (obs_dout[g] !== want) begin bad++; $display("FAIL stall_dout g=%0d got=%h want=%h", g, obs_dout[g], want); end
      total++; if (obs_grp[g] !== GW'(g)) begin bad++; $display("FAIL stall_grp got=%0d want=%0d", obs_grp[g], g); end
    end
  endtask

  task automatic test_random(input int npix);
    logic [IC*N-1:0] x;
    logic [W-1:0] want;
    int idx;
    for (int i = 0; i < npix; i++) begin
      set_random();
      x = rand_pixel();
      idx = pix_cnt % PIXELS;
      for (int g = 0; g < GROUPS; g++) exp_q.push_back(model_beat(x, g));
      drive_pixel(x, -1, 0);
      total++; if (obs_lat != IC + 1) begin bad++; $display("FAIL rand_latency got=%0d want=%0d", obs_lat, IC + 1); end
      for (int g = 0; g < GROUPS; g++) begin
        want = exp_q.pop_front();
        total++; if (obs_dout[g] !== want) begin bad++; $display("FAIL rand_dout i=%0d g=%0d got=%h want=%h", i, g, obs_dout[g], want); end
        total++; if (obs_last[g] !== (idx == PIXELS - 1 && g == GROUPS - 1)) begin bad++; $display("FAIL rand_last i=%0d g=%0d got=%b", i, g, obs_last[g]); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    int nb;
    int seen;
    set_random();
    in_din = rand_pixel(); in_vld = 1'b1; out_rdy = 1'b1;
    cyc = 0;
    while (!in_rdy && cyc < 64) begin
      @(negedge clk); cyc++;
    end
    @(negedge clk);
    in_vld = 1'b0;
    nb = 0; cyc = 0;
    while (nb < 2 && cyc < 100) begin
      if (out_vld) nb++;
      @(negedge clk); cyc++;
    end
    total++; if (nb != 2) begin bad++; $display("FAIL mid_reset_beats got=%0d want=2", nb); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; pix_cnt = 0; seen = 0;
    total++; if (out_grp !== '0) begin bad++; $display("FAIL mid_reset_grp got=%0d want=0", out_grp); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL mid_reset_in_rdy got=%b want=1", in_rdy); end
    for (int i = 0; i < 20; i++) begin
      if (out_vld) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_reset_out_vld cycles=%0d want=0", seen); end
  endtask

  // Back-to-back frames starting from pixel 0; out_last must appear on the final beat only.
  task automatic test_back_to_back(input int nframes);
    logic [IC*N-1:0] x;
    logic [W-1:0] want;
    int last_cnt;
    int last_pos;
    int idx;
    set_random();
    for (int f = 0; f < nframes; f++) begin
      fd_count = 0; last_cnt = 0; last_pos = -1;
      for (int i = 0; i < PIXELS; i++) begin
        x = rand_pixel();
        idx = pix_cnt % PIXELS;
        for (int g = 0; g < GROUPS; g++) exp_q.push_back(model_beat(x, g));
        drive_pixel(x, -1, 0);
        if (i == 0) begin
          total++; if (obs_grp[0] !== '0) begin bad++; $display("FAIL b2b_first_grp got=%0d want=0", obs_grp[0]); end
          total++; if (idx != 0) begin bad++; $display("FAIL b2b_start_index got=%0d want=0", idx); end
        end
        for (int g = 0; g < GROUPS; g++) begin
          want = exp_q.pop_front();
          total++; if (obs_dout[g] !== want) begin bad++; $display("FAIL b2b_dout f=%0d i=%0d g=%0d got=%h want=%h", f, i, g, obs_dout[g], want); end
          if (obs_last[g] === 1'b1) begin
            last_cnt++; last_pos = i * GROUPS + g + 1;
          end
        end
      end
      total++; if (last_cnt != 1) begin bad++; $display("FAIL b2b_last_count f=%0d got=%0d want=1", f, last_cnt); end
      total++; if (last_pos != PIXELS * GROUPS) begin bad++; $display("FAIL b2b_last_pos f=%0d got=%0d want=%0d", f, last_pos, PIXELS * GROUPS); end
      total++; if (fd_count != 1) begin bad++; $display("FAIL b2b_frame_done_count f=%0d got=%0d want=1", f, fd_count); end
      total++; if (obs_fd_after !== 1'b1) begin bad++; $display("FAIL b2b_frame_done_timing f=%0d got=%b want=1", f, obs_fd_after); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    fd_count = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_bias_shift();
    test_stall();
    test_random(10);
    test_mid_reset();
    test_back_to_back(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
